data_mem_lsu: RTL and testbench

DATA_MEM_LSU -- requirements
Module: data_mem_lsu

---
 rtl/dmem_pkg.sv | 25 ++
 rtl/dmem_align.sv | 48 ++++
 rtl/data_mem_lsu.sv | 124 ++++++++++++
 tb/tb_data_mem_lsu.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared definitions for the 64-bit data memory load/store unit:
// access size encodings, FSM states and the alignment helper.
package dmem_pkg;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2,
    SZ_D = 2'd3
  } size_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  // Natural alignment: the offset must be a multiple of the access width.
  function automatic logic misaligned(input logic [1:0] sz, input logic [2:0] off);
    logic [3:0] lsb_mask;
    lsb_mask = (4'd1 << sz) - 4'd1;
    return (off & lsb_mask[2:0]) != 3'd0;
  endfunction

endpackage

// File: rtl/dmem_align.sv
// Byte-lane steering for the LSU: store byte-enable mask and lane placement,
// load lane extraction with sign or zero extension.
module dmem_align
  import dmem_pkg::*;
(
  input  logic [1:0]  st_size,
  input  logic [2:0]  st_offset,
  input  logic [63:0] st_data,
  output logic [7:0]  st_mask,
  output logic [63:0] st_lanes,
  input  logic [1:0]  ld_size,
  input  logic [2:0]  ld_offset,
  input  logic        ld_unsigned,
  input  logic [63:0] ld_word,
  output logic [63:0] ld_data
);

  logic [7:0]  base_mask;
  logic [63:0] shifted;

  always_comb begin
    base_mask = 8'hFF;
    case (size_t'(st_size))
      SZ_B:    base_mask = 8'h01;
      SZ_H:    base_mask = 8'h03;
      SZ_W:    base_mask = 8'h0F;
      default: base_mask = 8'hFF;
    endcase
    st_mask  = base_mask << st_offset;
    st_lanes = st_data << {st_offset, 3'b000};
  end

  // Double loads ignore ld_unsigned: there is nothing left to extend.
  always_comb begin
    shifted = ld_word >> {ld_offset, 3'b000};
    ld_data = shifted;
    case (size_t'(ld_size))
      SZ_B: ld_data = ld_unsigned ? {56'd0, shifted[7:0]}
                                  : {{56{shifted[7]}}, shifted[7:0]};
      SZ_H: ld_data = ld_unsigned ? {48'd0, shifted[15:0]}
                                  : {{48{shifted[15]}}, shifted[15:0]};
      SZ_W: ld_data = ld_unsigned ? {32'd0, shifted[31:0]}
                                  : {{32{shifted[31]}}, shifted[31:0]};
      default: ld_data = shifted;
    endcase
  end

endmodule

// File: rtl/data_mem_lsu.sv
// Single-ported 64-bit data memory with a fixed-latency load/store handshake.
// Define DMEM_TEST_INIT_EN to preload words 0..4 with 10,20,30,40,50.
module data_mem_lsu
  import dmem_pkg::*;
#(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  output logic        rsp_valid,
  output logic [63:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [2:0] CNT_INIT = (LATENCY == 0) ? 3'd0 : 3'(LATENCY - 1);

  state_t      state_reg, state_next;
  logic [2:0]  cnt_reg, cnt_next;
  logic        we_reg, err_reg, uns_reg;
  logic [1:0]  size_reg;
  logic [2:0]  off_reg;
  logic [63:0] rd_word_reg;

  logic          accept, req_err, wr_en;
  logic [AW-1:0] widx;
  logic [7:0]    st_mask;
  logic [63:0]   st_lanes, ld_data;

`ifdef DMEM_TEST_INIT_EN
  logic [63:0] mem [DEPTH] = '{0: 64'd10, 1: 64'd20, 2: 64'd30, 3: 64'd40, 4: 64'd50,
                               default: 64'd0};
`else
  logic [63:0] mem [DEPTH] = '{default: 64'd0};
`endif

  assign req_ready = (state_reg == IDLE);
  assign accept    = req_valid && req_ready && rst_n;
  assign widx      = req_addr[3+AW-1:3];
  // Any set index bit above the array range is an error, never a wrap.
  assign req_err   = misaligned(req_size, req_addr[2:0]) || (req_addr[63:3+AW] != '0);
  assign wr_en     = accept && req_we && !req_err;

  dmem_align u_align (
    .st_size     (req_size),
    .st_offset   (req_addr[2:0]),
    .st_data     (req_wdata),
    .st_mask     (st_mask),
    .st_lanes    (st_lanes),
    .ld_size     (size_reg),
    .ld_offset   (off_reg),
    .ld_unsigned (uns_reg),
    .ld_word     (rd_word_reg),
    .ld_data     (ld_data)
  );

  // Read-before-write RAM port; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (accept) rd_word_reg <= mem[widx];
    if (wr_en) begin
      for (int i = 0; i < 8; i++) begin
        if (st_mask[i]) mem[widx][i*8 +: 8] <= st_lanes[i*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      cnt_reg   <= 3'd0;
      we_reg    <= 1'b0;
      err_reg   <= 1'b0;
      uns_reg   <= 1'b0;
      size_reg  <= 2'd0;
      off_reg   <= 3'd0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      if (accept) begin
        we_reg   <= req_we;
        err_reg  <= req_err;
        uns_reg  <= req_unsigned;
        size_reg <= req_size;
        off_reg  <= req_addr[2:0];
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      IDLE: begin
        if (req_valid) begin
          if (LATENCY == 0) begin
            state_next = RESP;
          end else begin
            state_next = WAIT;
            cnt_next   = CNT_INIT;
          end
        end
      end
      WAIT: begin
        if (cnt_reg == 3'd0) state_next = RESP;
        else                 cnt_next   = cnt_reg - 3'd1;
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign rsp_valid = (state_reg == RESP);
  assign rsp_err   = rsp_valid && err_reg;
  assign rsp_rdata = (rsp_valid && !we_reg && !err_reg) ? ld_data : 64'd0;

endmodule

// File: tb/tb_data_mem_lsu.sv
// Directed bench for data_mem_lsu: one LATENCY=1 instance for the data path,
// one LATENCY=3 instance for the mid-operation reset scenario.
module tb_data_mem_lsu;
  import dmem_pkg::*;

  localparam logic [63:0] W0_INIT =
`ifdef DMEM_TEST_INIT_EN
    64'd10;
`else
    64'd0;
`endif
  localparam logic [63:0] W2_INIT =
`ifdef DMEM_TEST_INIT_EN
    64'd30;
`else
    64'd0;
`endif

  logic        clk;
  logic        rst1_n, rst3_n;
  logic        valid1, valid3;
  logic        ready1, ready3;
  logic        req_we, req_unsigned;
  logic [1:0]  req_size;
  logic [63:0] req_addr, req_wdata;
  logic        rvalid1, rvalid3, rerr1, rerr3;
  logic [63:0] rdata1, rdata3;

  int total = 0;
  int bad   = 0;
  bit sel   = 1'b0;

  logic        m_ready, m_valid, m_err;
  logic [63:0] m_rdata;
  assign m_ready = sel ? ready3  : ready1;
  assign m_valid = sel ? rvalid3 : rvalid1;
  assign m_err   = sel ? rerr3   : rerr1;
  assign m_rdata = sel ? rdata3  : rdata1;

  data_mem_lsu #(.DEPTH(1024), .LATENCY(1)) dut (
    .clk(clk), .rst_n(rst1_n), .req_valid(valid1), .req_ready(ready1),
    .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rvalid1), .rsp_rdata(rdata1), .rsp_err(rerr1)
  );

  data_mem_lsu #(.DEPTH(1024), .LATENCY(3)) dut3 (
    .clk(clk), .rst_n(rst3_n), .req_valid(valid3), .req_ready(ready3),
    .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rvalid3), .rsp_rdata(rdata3), .rsp_err(rerr3)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%016h expected=0x%016h", tag, got, exp);
    end
  endtask

  // Issue one request; latency counts falling edges from accept to rsp_valid.
  task automatic do_req(input bit s3, input logic we, input logic [1:0] sz, input logic uns,
                        input logic [63:0] a, input logic [63:0] wd,
                        output logic [63:0] rd, output logic er, output int lat);
    int n;
    bit seen;
    sel = s3;
    n = 0;
    @(negedge clk);
    while (!m_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("ready_wait", 64'(m_ready), 64'd1);
    req_we = we; req_size = sz; req_unsigned = uns; req_addr = a; req_wdata = wd;
    if (s3) valid3 = 1'b1; else valid1 = 1'b1;
    @(posedge clk);
    #1;
    valid1 = 1'b0;
    valid3 = 1'b0;
    rd = '0; er = 1'b0; lat = 99; seen = 1'b0;
    for (int i = 1; i <= 20 && !seen; i++) begin
      @(negedge clk);
      if (m_valid) begin
        rd = m_rdata; er = m_err; lat = i; seen = 1'b1;
      end
    end
    @(negedge clk);
    check("rsp_one_cycle", 64'(m_valid), 64'd0);
  endtask

  task automatic xfer(input string tag, input bit s3, input logic we, input logic [1:0] sz,
                      input logic uns, input logic [63:0] a, input logic [63:0] wd,
                      input logic [63:0] exp_rd, input logic exp_er, input int exp_lat);
    logic [63:0] rd;
    logic er;
    int lat;
    do_req(s3, we, sz, uns, a, wd, rd, er, lat);
    check({tag, "_rdata"}, rd, exp_rd);
    check({tag, "_err"}, 64'(er), 64'(exp_er));
    check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    $display("txn %-10s we=%0d sz=%0d uns=%0d addr=0x%0h rdata=0x%016h err=%0d lat=%0d",
             tag, we, sz, uns, a, rd, er, lat);
  endtask

  initial begin
    bit saw_rsp;
    rst1_n = 1'b0; rst3_n = 1'b0;
    valid1 = 1'b0; valid3 = 1'b0;
    req_we = 1'b0; req_size = 2'd0; req_unsigned = 1'b0;
    req_addr = '0; req_wdata = '0;

    // Reset state, with a request held present that must not be accepted.
    #2;
    valid1 = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", 64'(ready1), 64'd1);
    check("rst_rsp_valid", 64'(rvalid1), 64'd0);
    check("rst_rsp_rdata", rdata1, 64'd0);
    check("rst_rsp_err", 64'(rerr1), 64'd0);
    valid1 = 1'b0;
    @(negedge clk);
    rst1_n = 1'b1; rst3_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_ready", 64'(ready1), 64'd1);

    xfer("ld_init", 0, 0, SZ_D, 0, 64'h10, 64'd0, W2_INIT, 0, 2);
    xfer("sd_28", 0, 1, SZ_D, 0, 64'h28, 64'h8877665544332211, 64'd0, 0, 2);
    xfer("lb_2f", 0, 0, SZ_B, 0, 64'h2F, 64'd0, 64'hFFFFFFFFFFFFFF88, 0, 2);
    xfer("lbu_2f", 0, 0, SZ_B, 1, 64'h2F, 64'd0, 64'h0000000000000088, 0, 2);
    xfer("sh_2a", 0, 1, SZ_H, 0, 64'h2A, 64'h000000000000BEEF, 64'd0, 0, 2);
    xfer("ld_28", 0, 0, SZ_D, 0, 64'h28, 64'd0, 64'h88776655BEEF2211, 0, 2);
    xfer("ldu_28", 0, 0, SZ_D, 1, 64'h28, 64'd0, 64'h88776655BEEF2211, 0, 2);
    xfer("lh_2a", 0, 0, SZ_H, 0, 64'h2A, 64'd0, 64'hFFFFFFFFFFFFBEEF, 0, 2);
    xfer("lhu_2a", 0, 0, SZ_H, 1, 64'h2A, 64'd0, 64'h000000000000BEEF, 0, 2);
    xfer("lw_2c", 0, 0, SZ_W, 0, 64'h2C, 64'd0, 64'hFFFFFFFF88776655, 0, 2);
    xfer("lwu_2c", 0, 0, SZ_W, 1, 64'h2C, 64'd0, 64'h0000000088776655, 0, 2);
    xfer("lw_2a_mis", 0, 0, SZ_W, 0, 64'h2A, 64'd0, 64'd0, 1, 2);
    xfer("sh_29_mis", 0, 1, SZ_H, 0, 64'h29, 64'h000000000000FFFF, 64'd0, 1, 2);
    xfer("ld_28_keep", 0, 0, SZ_D, 0, 64'h28, 64'd0, 64'h88776655BEEF2211, 0, 2);
    xfer("sd_oor", 0, 1, SZ_D, 0, 64'h2000, 64'h00000000DEADBEEF, 64'd0, 1, 2);
    xfer("ld_oor", 0, 0, SZ_D, 0, 64'h2000, 64'd0, 64'd0, 1, 2);
    xfer("ld_0_keep", 0, 0, SZ_D, 0, 64'h0, 64'd0, W0_INIT, 0, 2);
    xfer("sb_30", 0, 1, SZ_B, 0, 64'h30, 64'h00000000000000A5, 64'd0, 0, 2);
    xfer("sw_34", 0, 1, SZ_W, 0, 64'h34, 64'hFFFFFFFF11223344, 64'd0, 0, 2);
    xfer("ld_30", 0, 0, SZ_D, 0, 64'h30, 64'd0, 64'h11223344000000A5, 0, 2);
    xfer("lb_30", 0, 0, SZ_B, 0, 64'h30, 64'd0, 64'hFFFFFFFFFFFFFFA5, 0, 2);

    // LATENCY=3: reset lands in the second WAIT cycle of a store to 0x0.
    sel = 1'b1;
    @(negedge clk);
    req_we = 1'b1; req_size = SZ_D; req_unsigned = 1'b0;
    req_addr = 64'h0; req_wdata = 64'hCAFEF00D12345678;
    valid3 = 1'b1;
    @(posedge clk);
    #1;
    valid3 = 1'b0;
    @(posedge clk);
    #1;
    rst3_n = 1'b0;
    #1;
    check("mid_rst_valid", 64'(rvalid3), 64'd0);
    check("mid_rst_ready", 64'(ready3), 64'd1);
    saw_rsp = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (rvalid3) saw_rsp = 1'b1;
    end
    rst3_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (rvalid3) saw_rsp = 1'b1;
    end
    check("mid_rst_dropped", 64'(saw_rsp), 64'd0);
    xfer("l3_ld_0", 1, 0, SZ_D, 0, 64'h0, 64'd0, 64'hCAFEF00D12345678, 0, 4);
    xfer("l3_lhu_2", 1, 0, SZ_H, 1, 64'h2, 64'd0, 64'h0000000000001234, 0, 4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
